// File: rtl/packet_flit_assembler_pkg.sv
// Shared types for the flit assembler: flit type and FSM encodings, flit field
// positions and the byte-lane XOR checksum.
package packet_flit_assembler_pkg;

  typedef enum logic [1:0] {
    HEAD = 2'b00,
    BODY = 2'b01,
    TAIL = 2'b10,
    NOPE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RECV = 2'b01,
    DROP = 2'b10,
    DONE = 2'b11
  } assembler_state_e;

  localparam int FLIT_BITS      = 64;
  localparam int FLIT_TYPE_MSB  = 63;
  localparam int FLIT_TYPE_LSB  = 62;
  localparam int LEN_MSB        = 61;
  localparam int LEN_LSB        = 58;
  localparam int LEN_WIDTH      = LEN_MSB - LEN_LSB + 1;
  localparam int CHECKSUM_WIDTH = 8;

  function automatic logic [CHECKSUM_WIDTH-1:0] flit_checksum(input logic [FLIT_BITS-1:0] flit);
    logic [CHECKSUM_WIDTH-1:0] acc;
    acc = 8'h00;
    for (int i = 0; i < FLIT_BITS / CHECKSUM_WIDTH; i++) begin
      acc = acc ^ flit[i*CHECKSUM_WIDTH +: CHECKSUM_WIDTH];
    end
    return acc;
  endfunction

endpackage

// File: rtl/packet_flit_assembler.sv
// Assembles a serial flit stream into whole packets, checking order, length and
// checksum, and offers each packet downstream over a valid/ready handshake.
module packet_flit_assembler
  import packet_flit_assembler_pkg::*;
#(
  parameter int FLIT_WIDTH = FLIT_BITS,
  parameter int MAX_FLITS  = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [FLIT_WIDTH-1:0]             in_flit,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [MAX_FLITS*FLIT_WIDTH-1:0]   out_packet,
  output logic [$clog2(MAX_FLITS+1)-1:0]    out_flit_num,
  output logic                              out_error
);

  localparam int CNT_W = $clog2(MAX_FLITS + 1);
  localparam int IDX_W = $clog2(MAX_FLITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_FLITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_FLITS);

  logic [FLIT_WIDTH-1:0]     buf_r [MAX_FLITS];
  assembler_state_e          state_r;
  logic [CNT_W-1:0]          cnt_r;
  logic [CHECKSUM_WIDTH-1:0] csum_r;
  logic [LEN_WIDTH-1:0]      len_r;
  logic                      err_r;
  logic                      out_valid_r;
  logic                      in_ready_r;

  flit_type_e                ftype_s;
  logic [LEN_WIDTH-1:0]      len_s;
  logic                      len_ok_s;
  logic                      xfer_s;
  logic [IDX_W-1:0]          idx_s;
  logic                      tail_bad_s;

  assign ftype_s    = flit_type_e'(in_flit[FLIT_TYPE_MSB:FLIT_TYPE_LSB]);
  assign len_s      = in_flit[LEN_MSB:LEN_LSB];
  assign len_ok_s   = (int'(len_s) >= 32'sd2) && (int'(len_s) <= MAX_FLITS);
  assign xfer_s     = in_valid && in_ready_r;
  assign idx_s      = cnt_r[IDX_W-1:0];
  // len_r is only used here once a legal length was latched, so it fits CNT_W.
  assign tail_bad_s = (in_flit[CHECKSUM_WIDTH-1:0] != csum_r) ||
                      (CNT_W'(len_r) != cnt_r + CNT_ONE);

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign out_flit_num = cnt_r;
  assign out_error    = err_r;

  for (genvar gi = 0; gi < MAX_FLITS; gi++) begin : g_slot
    assign out_packet[gi*FLIT_WIDTH +: FLIT_WIDTH] = buf_r[gi];
  end

  // Assembler FSM together with the flit store and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_FLITS; i++) buf_r[i] <= '0;
      state_r     <= IDLE;
      cnt_r       <= '0;
      csum_r      <= '0;
      len_r       <= '0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
    end else if (xfer_s && ftype_s == HEAD && (state_r == IDLE || state_r == RECV)) begin
      // A head always restarts the packet; arriving mid-packet it is an order error.
      for (int i = 1; i < MAX_FLITS; i++) buf_r[i] <= '0;
      buf_r[0]   <= in_flit;
      cnt_r      <= CNT_ONE;
      csum_r     <= flit_checksum(in_flit);
      len_r      <= len_s;
      err_r      <= (state_r == RECV) || !len_ok_s;
      state_r    <= len_ok_s ? RECV : DROP;
      in_ready_r <= 1'b1;
    end else begin
      in_ready_r <= (state_r != DONE) || out_ready;
      case (state_r)
        IDLE: begin
          if (xfer_s && (ftype_s == BODY || ftype_s == TAIL)) begin
            buf_r[0] <= in_flit;
            cnt_r    <= CNT_ONE;
            err_r    <= 1'b1;
            if (ftype_s == TAIL) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              in_ready_r  <= 1'b0;
            end else begin
              state_r <= DROP;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RECV: begin
          if (xfer_s && ftype_s == BODY) begin
            if (cnt_r == CNT_LAST) begin
              err_r   <= 1'b1;
              state_r <= DROP;
            end else begin
              buf_r[idx_s] <= in_flit;
              cnt_r        <= cnt_r + CNT_ONE;
              csum_r       <= csum_r ^ flit_checksum(in_flit);
            end
          end else if (xfer_s && ftype_s == TAIL) begin
            buf_r[idx_s] <= in_flit;
            cnt_r        <= cnt_r + CNT_ONE;
            err_r        <= err_r | tail_bad_s;
            state_r      <= DONE;
            out_valid_r  <= 1'b1;
            in_ready_r   <= 1'b0;
          end else begin
            state_r <= RECV;
          end
        end
        DROP: begin
          if (xfer_s && ftype_s != NOPE) begin
            if (cnt_r < CNT_MAX) begin
              buf_r[idx_s] <= in_flit;
              cnt_r        <= cnt_r + CNT_ONE;
            end
            if (ftype_s == TAIL) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              in_ready_r  <= 1'b0;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            for (int i = 0; i < MAX_FLITS; i++) buf_r[i] <= '0;
            cnt_r       <= '0;
            csum_r      <= '0;
            len_r       <= '0;
            err_r       <= 1'b0;
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packet_flit_assembler.sv
// Directed self-checking bench for packet_flit_assembler; every scenario is run
// once plain and once with NOPE fillers interleaved.
module tb_packet_flit_assembler;

  localparam logic [63:0] H3   = 64'h0C00_0000_0000_0000;  // HEAD L=3, checksum 8'h0C
  localparam logic [63:0] B1   = 64'h4000_0000_0000_00A5;  // BODY, checksum 8'hE5
  localparam logic [63:0] T3   = 64'h8000_0000_0000_00E9;  // TAIL for H3,B1
  localparam logic [63:0] T3X  = 64'h8000_0000_0000_00E8;  // corrupted checksum
  localparam logic [63:0] H2   = 64'h0800_0000_0000_0011;  // HEAD L=2, checksum 8'h19
  localparam logic [63:0] T2   = 64'h8000_0000_0000_0019;  // TAIL for H2
  localparam logic [63:0] H9   = 64'h2400_0000_0000_0000;  // HEAD L=9, illegal
  localparam logic [63:0] NOP  = 64'hC000_0000_0000_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_flit;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_packet;
  logic [3:0]   out_flit_num;
  logic         out_error;

  int passed = 0;
  int total  = 0;

  packet_flit_assembler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_flit      (in_flit),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_packet   (out_packet),
    .out_flit_num (out_flit_num),
    .out_error    (out_error)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [63:0] f);
    int waited;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_flit  = f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_flit  = '0;
  endtask

  task automatic send_seq(input logic [63:0] seq[$], input bit nopes);
    foreach (seq[i]) begin
      if (nopes && i > 0) send(NOP);
      send(seq[i]);
    end
  endtask

  task automatic check_out(input string name, input logic [511:0] exp_pkt,
                           input logic [3:0] exp_num, input logic exp_err);
    total++;
    if (out_valid !== 1'b1 || out_packet !== exp_pkt || out_flit_num !== exp_num ||
        out_error !== exp_err)
      $display("FAIL %s: valid=%0b num=%0d err=%0b pkt[191:0]=%h required valid=1 num=%0d err=%0b pkt[191:0]=%h",
               name, out_valid, out_flit_num, out_error, out_packet[191:0], exp_num, exp_err,
               exp_pkt[191:0]);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_flit = '0; out_ready = 1'b1;
    #12;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_packet !== '0 ||
        out_flit_num !== 4'd0 || out_error !== 1'b0)
      $display("FAIL reset_state: in_ready=%0b valid=%0b num=%0d err=%0b required all 0",
               in_ready, out_valid, out_flit_num, out_error);
    else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_release: in_ready=%0b required 1", in_ready);
    else passed++;
  endtask

  task automatic test_clean(input bit nopes);
    logic [511:0] exp;
    exp = '0; exp[63:0] = H3; exp[127:64] = B1; exp[191:128] = T3;
    out_ready = 1'b1;
    send_seq('{H3, B1, T3}, nopes);
    check_out("clean_packet", exp, 4'd3, 1'b0);
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL clean_handshake: valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_backpressure(input bit nopes);
    logic [511:0] exp;
    exp = '0; exp[63:0] = H3; exp[127:64] = B1; exp[191:128] = T3;
    out_ready = 1'b0;
    send_seq('{H3, B1, T3}, nopes);
    for (int c = 0; c < 5; c++) begin
      check_out("stall_hold", exp, 4'd3, 1'b0);
      total++;
      if (in_ready !== 1'b0) $display("FAIL stall_in_ready: in_ready=%0b required 0", in_ready);
      else passed++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL stall_release: valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_bad_checksum(input bit nopes);
    logic [511:0] exp;
    exp = '0; exp[63:0] = H3; exp[127:64] = B1; exp[191:128] = T3X;
    out_ready = 1'b1;
    send_seq('{H3, B1, T3X}, nopes);
    check_out("bad_checksum", exp, 4'd3, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic test_drop(input bit nopes);
    int pulses;
    out_ready = 1'b0;
    send_seq('{H9, B1, B1, B1, T3}, nopes);
    total++;
    if (out_valid !== 1'b1 || out_error !== 1'b1 || out_packet[63:0] !== H9)
      $display("FAIL drop_packet: valid=%0b err=%0b slot0=%h required 1 1 %h",
               out_valid, out_error, out_packet[63:0], H9);
    else passed++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) pulses++;
      @(posedge clk); #1;
    end
    total++;
    if (pulses != 0) $display("FAIL drop_once: extra valid cycles=%0d required 0", pulses);
    else passed++;
  endtask

  task automatic test_order_error(input bit nopes);
    logic [511:0] exp;
    exp = '0; exp[63:0] = H2; exp[127:64] = T2;
    out_ready = 1'b1;
    send_seq('{H3, B1, H2, T2}, nopes);
    check_out("order_error", exp, 4'd2, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset(input bit nopes);
    logic [511:0] exp;
    exp = '0; exp[63:0] = H2; exp[127:64] = T2;
    out_ready = 1'b1;
    send_seq('{H3, B1}, nopes);
    rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b0 || out_packet !== '0)
      $display("FAIL mid_reset_clear: in_ready=%0b pkt[127:0]=%h required 0 0",
               in_ready, out_packet[127:0]);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_seq('{H2, T2}, nopes);
    check_out("after_reset", exp, 4'd2, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    for (int n = 0; n < 2; n++) begin
      test_clean(n[0]);
      test_backpressure(n[0]);
      test_bad_checksum(n[0]);
      test_drop(n[0]);
      test_order_error(n[0]);
      test_mid_reset(n[0]);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
